// File: rtl/zero_count_reg_pkg.sv
// zero_count_reg_pkg: shared scan-mode constants and count-width helper
// for the zero counter and its combinational tree.
package zero_count_reg_pkg;

    localparam int LZC_TRAILING = 0;
    localparam int LZC_LEADING  = 1;

    // Count width is clog2 of the vector width, but never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/zero_count_reg_tree.sv
// zero_count_tree: combinational first-set-bit finder built as a binary tree.
// Ports:
//   in_i    [WIDTH]      vector to scan
//   cnt_o   [CNT_WIDTH]  zeros before the first set bit in the scan direction
//   empty_o              high when in_i is all zeros
module zero_count_tree
    import zero_count_reg_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int MODE  = LZC_TRAILING
) (
    input  logic [WIDTH-1:0]            in_i,
    output logic [cnt_width(WIDTH)-1:0] cnt_o,
    output logic                        empty_o
);

    localparam int CW    = cnt_width(WIDTH);
    localparam int NLEAF = 1 << $clog2(WIDTH);
    localparam int NNODE = 2 * NLEAF - 1;

    // Leaves are ordered by distance from the scan origin, so leaf j always
    // carries count j and every node simply prefers its left child.
    logic [NLEAF-1:0] w_leaf_v;
    logic [NNODE-1:0] w_node_v;
    logic [CW-1:0]    w_node_i [NNODE];

    for (genvar i = 0; i < NLEAF; i++) begin : g_leaf
        if (i < WIDTH) begin : g_real
            assign w_leaf_v[i] = in_i[(MODE == LZC_LEADING) ? WIDTH - 1 - i : i];
        end else begin : g_pad
            // Padding leaves are never valid, so they can never win a node.
            assign w_leaf_v[i] = 1'b0;
        end
    end

    // Heap layout: node n has children 2n+1 and 2n+2, leaves start at NLEAF-1.
    always_comb begin
        w_node_v = '0;
        w_node_i = '{default: '0};
        for (int i = 0; i < NLEAF; i++) begin
            w_node_v[NLEAF-1+i] = w_leaf_v[i];
            w_node_i[NLEAF-1+i] = CW'(i);
        end
        for (int n = NLEAF - 2; n >= 0; n--) begin
            w_node_v[n] = w_node_v[2*n+1] | w_node_v[2*n+2];
            w_node_i[n] = w_node_v[2*n+1] ? w_node_i[2*n+1] : w_node_i[2*n+2];
        end
    end

    // An empty vector must report zero, not whatever index the root carried.
    assign cnt_o   = w_node_v[0] ? w_node_i[0] : '0;
    assign empty_o = ~w_node_v[0];

endmodule

// File: rtl/zero_count_reg.sv
// zero_count_reg: leading/trailing zero counter with optional output register.
// Ports:
//   clk_i    clock (only used when OUT_REG=1)
//   rst_ni   asynchronous active-low reset (only used when OUT_REG=1)
//   in_i     [WIDTH] vector to scan
//   cnt_o    [CNT_WIDTH] zeros before the first set bit
//   empty_o  high when the scanned vector is all zeros
module zero_count_reg
    import zero_count_reg_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MODE    = LZC_TRAILING,
    parameter int OUT_REG = 0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [WIDTH-1:0]            in_i,
    output logic [cnt_width(WIDTH)-1:0] cnt_o,
    output logic                        empty_o
);

    localparam int CNT_WIDTH = cnt_width(WIDTH);

    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "zero_count_reg: WIDTH must be at least 1");
    end

    logic [CNT_WIDTH-1:0] w_cnt;
    logic                 w_empty;

    zero_count_tree #(
        .WIDTH (WIDTH),
        .MODE  (MODE)
    ) u_tree (
        .in_i    (in_i),
        .cnt_o   (w_cnt),
        .empty_o (w_empty)
    );

    if (OUT_REG != 0) begin : g_reg
        logic [CNT_WIDTH-1:0] r_cnt;
        logic                 r_empty;
        // Reset value matches the empty-vector result so downstream sees "no grant".
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_cnt   <= '0;
                r_empty <= 1'b1;
            end else begin
                r_cnt   <= w_cnt;
                r_empty <= w_empty;
            end
        end
        assign cnt_o   = r_cnt;
        assign empty_o = r_empty;
    end else begin : g_comb
        logic w_unused;
        assign w_unused = clk_i ^ rst_ni;
        assign cnt_o    = w_cnt;
        assign empty_o  = w_empty;
    end

endmodule

// File: tb/tb_zero_count_reg.sv
// tb_zero_count_reg: scoreboard bench for zero_count_reg across several configurations.
module tb_zero_count_reg;

    typedef struct {
        int sel;
        int due;
        int cnt;
        bit empty;
    } exp_t;

    typedef struct {
        int          sel;
        logic [31:0] v;
        int          cnt;
        bit          empty;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in32;
    logic [4:0]  in5;
    logic [0:0]  in1;
    logic [7:0]  in8r;
    logic [7:0]  in8;

    logic [4:0] c32t, c32l;
    logic [2:0] c5, c8r, c8t, c8l;
    logic [0:0] c1;
    logic       e32t, e32l, e5, e1, e8r, e8t, e8l;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    zero_count_reg #(.WIDTH(32), .MODE(0), .OUT_REG(0)) u32t (
        .clk_i(clk), .rst_ni(rst_n), .in_i(in32), .cnt_o(c32t), .empty_o(e32t));
    zero_count_reg #(.WIDTH(32), .MODE(1), .OUT_REG(0)) u32l (
        .clk_i(clk), .rst_ni(rst_n), .in_i(in32), .cnt_o(c32l), .empty_o(e32l));
    zero_count_reg #(.WIDTH(5), .MODE(0), .OUT_REG(0)) u5 (
        .clk_i(clk), .rst_ni(rst_n), .in_i(in5), .cnt_o(c5), .empty_o(e5));
    zero_count_reg #(.WIDTH(1), .MODE(0), .OUT_REG(0)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .in_i(in1), .cnt_o(c1), .empty_o(e1));
    zero_count_reg #(.WIDTH(8), .MODE(0), .OUT_REG(1)) u8r (
        .clk_i(clk), .rst_ni(rst_n), .in_i(in8r), .cnt_o(c8r), .empty_o(e8r));
    zero_count_reg #(.WIDTH(8), .MODE(0), .OUT_REG(0)) u8t (
        .clk_i(clk), .rst_ni(rst_n), .in_i(in8), .cnt_o(c8t), .empty_o(e8t));
    zero_count_reg #(.WIDTH(8), .MODE(1), .OUT_REG(0)) u8l (
        .clk_i(clk), .rst_ni(rst_n), .in_i(in8), .cnt_o(c8l), .empty_o(e8l));

    function automatic int gold(input logic [31:0] v, input int w, input int mode);
        int r;
        bit found;
        r = 0;
        found = 0;
        for (int k = 0; k < w; k++) begin
            if (!found && v[(mode != 0) ? w - 1 - k : k]) begin
                r = k;
                found = 1;
            end
        end
        return r;
    endfunction

    function automatic string inst_name(input int sel);
        case (sel)
            0: return "w32_trail";
            1: return "w32_lead";
            2: return "w5_trail";
            3: return "w1";
            4: return "w8_reg";
            5: return "w8_trail";
            default: return "w8_lead";
        endcase
    endfunction

    task automatic push(input int sel, input int due, input int cnt, input bit empty);
        exp_t e;
        e.sel = sel;
        e.due = due;
        e.cnt = cnt;
        e.empty = empty;
        sb.push_back(e);
    endtask

    // Monitor: every expectation due by this cycle is compared mid-cycle.
    always @(negedge clk) begin
        for (int k = sb.size() - 1; k >= 0; k--) begin
            if (sb[k].due <= cyc) begin
                int a_cnt;
                bit a_emp;
                case (sb[k].sel)
                    0: begin a_cnt = int'(c32t); a_emp = e32t; end
                    1: begin a_cnt = int'(c32l); a_emp = e32l; end
                    2: begin a_cnt = int'(c5);   a_emp = e5;   end
                    3: begin a_cnt = int'(c1);   a_emp = e1;   end
                    4: begin a_cnt = int'(c8r);  a_emp = e8r;  end
                    5: begin a_cnt = int'(c8t);  a_emp = e8t;  end
                    default: begin a_cnt = int'(c8l); a_emp = e8l; end
                endcase
                checks++;
                if (a_cnt != sb[k].cnt || a_emp != sb[k].empty) begin
                    errors++;
                    $display("FAIL %s cyc=%0d: got cnt=%0d empty=%0b, expected cnt=%0d empty=%0b",
                             inst_name(sb[k].sel), cyc, a_cnt, a_emp, sb[k].cnt, sb[k].empty);
                end
                sb.delete(k);
            end
        end
    end

    vec_t dir[$] = '{
        '{0, 32'h0000_0100, 8,  1'b0},
        '{0, 32'h8000_0006, 1,  1'b0},
        '{1, 32'h8000_0006, 0,  1'b0},
        '{1, 32'h0000_0001, 31, 1'b0},
        '{0, 32'h0000_0000, 0,  1'b1},
        '{1, 32'h0000_0000, 0,  1'b1},
        '{1, 32'h0001_0000, 15, 1'b0},
        '{2, 32'h0000_0010, 4,  1'b0},
        '{2, 32'h0000_0006, 1,  1'b0},
        '{2, 32'h0000_0000, 0,  1'b1},
        '{3, 32'h0000_0001, 0,  1'b0},
        '{3, 32'h0000_0000, 0,  1'b1}
    };

    initial begin
        rst_n = 1'b1;
        in32 = '0; in5 = '0; in1 = '0; in8r = '0; in8 = '0;
        #2;
        rst_n = 1'b0;
        in8r = 8'h40;
        in32 = 32'h0000_0100;
        @(posedge clk); #1;
        push(4, cyc, 0, 1'b1);
        push(0, cyc, 8, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        push(4, cyc, 0, 1'b1);
        @(posedge clk); #1;
        push(4, cyc, 6, 1'b0);
        @(posedge clk); #1;
        in8r = 8'h01;
        rst_n = 1'b0;
        push(4, cyc, 0, 1'b1);
        @(posedge clk); #1;
        push(4, cyc, 0, 1'b1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        push(4, cyc, 0, 1'b0);
        foreach (dir[i]) begin
            @(posedge clk); #1;
            case (dir[i].sel)
                0, 1: in32 = dir[i].v;
                2: in5 = dir[i].v[4:0];
                default: in1 = dir[i].v[0:0];
            endcase
            push(dir[i].sel, cyc, dir[i].cnt, dir[i].empty);
        end
        for (int v = 0; v < 256; v++) begin
            logic [31:0] w;
            @(posedge clk); #1;
            w = 32'(v);
            in8 = w[7:0];
            in8r = w[7:0];
            push(5, cyc, gold(w, 8, 0), v == 0);
            push(6, cyc, gold(w, 8, 1), v == 0);
            push(4, cyc + 1, gold(w, 8, 0), v == 0);
        end
        for (int n = 0; n < 200; n++) begin
            logic [31:0] w;
            @(posedge clk); #1;
            w = $urandom & $urandom & (32'hFFFF_FFFF >> $urandom_range(31, 0));
            in32 = w;
            push(0, cyc, gold(w, 32, 0), w == 0);
            push(1, cyc, gold(w, 32, 1), w == 0);
        end
        for (int n = 0; n < 5 && sb.size() != 0; n++) @(posedge clk);
        @(negedge clk); #1;
        if (sb.size() != 0) begin
            checks += sb.size();
            errors += sb.size();
            $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish, expected finish before 1ms");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/zero_count_reg.md
Name: zero_count_reg

Overview:
- Parameterizable leading/trailing zero counter over a one-hot or multi-hot vector.
- Returns the index of the first set bit, scanning from LSB (trailing mode) or MSB (leading mode).
- Also reports whether the vector is empty (all zeros).
- Used by the address decoder / response mux to pick the lowest granted bank from a registered grant vector; an optional output register supports timing-critical placements.

Parameters:
- WIDTH, 32: input vector width; legal range ≥1.
- MODE, 0: 0 = trailing-zero count (scan from bit 0 upward); 1 = leading-zero count (scan from bit WIDTH-1 downward).
- OUT_REG, 0: 0 = outputs purely combinational; 1 = outputs registered, one cycle of latency.
- CNT_WIDTH, derived (not overridable): $clog2(WIDTH) when WIDTH>1, else 1.

Ports:
- clk_i  input  1  clock; used only when OUT_REG=1.
- rst_ni  input  1  asynchronous active-low reset; used only when OUT_REG=1.
- in_i  input  WIDTH  vector to scan.
- cnt_o  output  CNT_WIDTH  number of zeros before the first set bit in the scan direction.
- empty_o  output  1  high when in_i is all zeros.

Interface rule:
- One clock; reset is asynchronous and active-low, named clk_i and rst_ni.

Behaviour:
- MODE=0: cnt_o = index of the lowest set bit of in_i.
- MODE=1: cnt_o = (WIDTH-1) - index of the highest set bit, i.e. the count of leading zeros.
- Empty input (in_i == 0): empty_o=1 and cnt_o=0. Both are fixed requirements, never don't-care.
- Multi-hot input: only the first set bit in the scan direction matters; all others are ignored.
- Implementation: binary tree of ceil(log2 WIDTH) levels, pairwise comparison of (valid, index) nodes.
  - Leaves are padded to a power of two with zeros.
  - Padded leaves must never win.
  - Each node prefers the child nearer the scan origin when that child is valid.
- WIDTH=1: cnt_o is 1 bit and always 0; empty_o = ~in_i[0].
- Non-power-of-two WIDTH: cnt_o never exceeds WIDTH-1.
- OUT_REG=0:
  - No state; outputs follow in_i in the same cycle.
  - clk_i and rst_ni are ignored.
  - Reset has no effect on outputs.
- OUT_REG=1:
  - cnt_o and empty_o are captured on the rising edge of clk_i; latency is exactly 1 cycle.
  - Asynchronous reset forces cnt_o=0 and empty_o=1 immediately.
  - Outputs hold those values until the first clock edge after rst_ni deasserts.
  - Reset asserted mid-stream discards any pending value.
- No handshake: in_i is sampled every cycle (OUT_REG=1) or continuously (OUT_REG=0).
- Elaboration check: WIDTH=0 is fatal.

Decomposition:
- Shared package: a CNT_WIDTH helper function (clog2 with minimum 1) and MODE constants LZC_TRAILING=0 and LZC_LEADING=1.
- One sub-module, zero_count_tree: the purely combinational tree, parameterized by WIDTH and MODE.
- zero_count_reg wraps zero_count_tree and adds the optional output register.

Test Plan:
- WIDTH=32, MODE=0, OUT_REG=0, in_i=32'h0000_0100 -> cnt_o=8, empty_o=0 in the same cycle.
- WIDTH=32, MODE=0, in_i=32'h8000_0006 -> cnt_o=1. In MODE=1 with the same input -> cnt_o=0.
- WIDTH=32, MODE=1, in_i=32'h0000_0001 -> cnt_o=31. With in_i=0 in either mode -> cnt_o=0, empty_o=1.
- WIDTH=5, MODE=0, in_i=5'b10000 -> cnt_o=4 (3-bit output). WIDTH=1 with in_i=1 -> cnt_o=0, empty_o=0.
- OUT_REG=1, WIDTH=8:
  - Hold rst_ni low -> cnt_o=0, empty_o=1.
  - Release reset, drive in_i=8'h40 -> cnt_o=6 only after the next rising edge.
  - Assert rst_ni low mid-cycle -> outputs return to 0/1 without waiting for a clock edge.
- Exhaustive sweep, WIDTH=8, both modes, all 256 inputs -> match a golden model. Random multi-hot sweep at WIDTH=32 -> match the same golden model.
